// File: rtl/uart_rx_bit_sequencer.sv
// ---------------------------------------------------------------------------
// uart_rx_bit_sequencer
//
// Receive-side bit sequencer for the 16750-compatible UART. It watches the
// synchronized serial line on every 16x baud tick, confirms a start bit at
// mid-bit, samples data/parity/stop bits at the middle of each bit period,
// and hands the assembled character to the RX FIFO write logic with a
// one-cycle completion strobe.
//
// Ports:
//   CLK        in   system clock (single domain)
//   RST        in   asynchronous active-high reset
//   RXCLK      in   16x baud tick enable, one CLK wide
//   CLEAR      in   synchronous abort back to IDLE (outputs hold)
//   RXD        in   synchronized serial input, idle high
//   WLS[1:0]   in   word length select, data bits = 5 + WLS
//   PEN        in   parity enable
//   EPS        in   even parity select
//   SP         in   stick parity
//   DOUT[7:0]  out  received character, right-justified, upper bits zero
//   PE         out  parity error of the last character
//   FE         out  framing error (stop bit sampled low)
//   BI         out  break indication (whole frame low)
//   RXFINISHED out  one-CLK strobe, DOUT/PE/FE/BI valid
//   BUSY       out  high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module uart_rx_bit_sequencer (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RXCLK,
  input  logic       CLEAR,
  input  logic       RXD,
  input  logic [1:0] WLS,
  input  logic       PEN,
  input  logic       EPS,
  input  logic       SP,
  output logic [7:0] DOUT,
  output logic       PE,
  output logic       FE,
  output logic       BI,
  output logic       RXFINISHED,
  output logic       BUSY
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP,
    S_BRKWAIT
  } state_t;

  state_t     r_state, w_stateNext;
  logic [3:0] r_tickCnt, w_tickCntNext;
  logic [2:0] r_bitCnt, w_bitCntNext;
  logic [7:0] r_shift, w_shiftNext;
  logic       r_parErr, w_parErrNext;
  logic       r_parBit, w_parBitNext;
  logic [7:0] r_dout, w_doutNext;
  logic       r_pe, w_peNext;
  logic       r_fe, w_feNext;
  logic       r_bi, w_biNext;
  logic       r_finished, w_finishedNext;

  logic       w_midBit;
  logic       w_lastDataBit;
  logic       w_dataXor;
  logic       w_parErrCalc;

  // Data/parity/stop are sampled when the tick counter holds 15; since the
  // counter restarts at the confirmed start mid-point, 15 lands mid-bit.
  assign w_midBit      = (r_tickCnt == 4'd15);
  assign w_lastDataBit = (r_bitCnt == (3'd4 + {1'b0, WLS}));

  // The shift register is cleared at start confirmation, so unused upper
  // bits are zero and do not disturb the parity reduction.
  assign w_dataXor = ^r_shift;

  // Stick parity expects the fixed bit ~EPS; otherwise even parity wants
  // data^parity == 0 and odd parity wants it to be 1.
  always_comb begin
    w_parErrCalc = 1'b0;
    if (SP) begin
      w_parErrCalc = (RXD == EPS);
    end else if (EPS) begin
      w_parErrCalc = w_dataXor ^ RXD;
    end else begin
      w_parErrCalc = ~(w_dataXor ^ RXD);
    end
  end

  // Next-state and next-value logic. Everything advances only on a baud
  // tick; CLEAR overrides the tick and the completion strobe always drops
  // after one CLK.
  always_comb begin
    w_stateNext    = r_state;
    w_tickCntNext  = r_tickCnt;
    w_bitCntNext   = r_bitCnt;
    w_shiftNext    = r_shift;
    w_parErrNext   = r_parErr;
    w_parBitNext   = r_parBit;
    w_doutNext     = r_dout;
    w_peNext       = r_pe;
    w_feNext       = r_fe;
    w_biNext       = r_bi;
    w_finishedNext = 1'b0;

    if (CLEAR) begin
      w_stateNext   = S_IDLE;
      w_tickCntNext = 4'd0;
      w_bitCntNext  = 3'd0;
    end else if (RXCLK) begin
      case (r_state)
        S_IDLE: begin
          if (!RXD) begin
            w_tickCntNext = 4'd0;
            w_stateNext   = S_START;
          end
        end

        S_START: begin
          if (r_tickCnt == 4'd7) begin
            if (RXD) begin
              w_stateNext = S_IDLE;
            end else begin
              w_tickCntNext = 4'd0;
              w_bitCntNext  = 3'd0;
              w_shiftNext   = 8'h00;
              w_parErrNext  = 1'b0;
              w_parBitNext  = 1'b0;
              w_stateNext   = S_DATA;
            end
          end else begin
            w_tickCntNext = r_tickCnt + 4'd1;
          end
        end

        S_DATA: begin
          w_tickCntNext = r_tickCnt + 4'd1;
          if (w_midBit) begin
            w_shiftNext[r_bitCnt] = RXD;
            w_bitCntNext          = r_bitCnt + 3'd1;
            if (w_lastDataBit) begin
              w_stateNext = PEN ? S_PAR : S_STOP;
            end
          end
        end

        S_PAR: begin
          w_tickCntNext = r_tickCnt + 4'd1;
          if (w_midBit) begin
            w_parBitNext = RXD;
            w_parErrNext = w_parErrCalc;
            w_stateNext  = S_STOP;
          end
        end

        S_STOP: begin
          w_tickCntNext = r_tickCnt + 4'd1;
          if (w_midBit) begin
            w_doutNext     = r_shift;
            w_peNext       = PEN & r_parErr;
            w_feNext       = ~RXD;
            w_biNext       = (r_shift == 8'h00) && !RXD && (!PEN || !r_parBit);
            w_finishedNext = 1'b1;
            // A low stop bit means the line may be held in break; wait for
            // it to return high before hunting for a new start bit.
            w_stateNext    = RXD ? S_IDLE : S_BRKWAIT;
          end
        end

        S_BRKWAIT: begin
          if (RXD) begin
            w_stateNext = S_IDLE;
          end
        end

        default: begin
          w_stateNext = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_tickCnt  <= 4'd0;
      r_bitCnt   <= 3'd0;
      r_shift    <= 8'h00;
      r_parErr   <= 1'b0;
      r_parBit   <= 1'b0;
      r_dout     <= 8'h00;
      r_pe       <= 1'b0;
      r_fe       <= 1'b0;
      r_bi       <= 1'b0;
      r_finished <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_tickCnt  <= w_tickCntNext;
      r_bitCnt   <= w_bitCntNext;
      r_shift    <= w_shiftNext;
      r_parErr   <= w_parErrNext;
      r_parBit   <= w_parBitNext;
      r_dout     <= w_doutNext;
      r_pe       <= w_peNext;
      r_fe       <= w_feNext;
      r_bi       <= w_biNext;
      r_finished <= w_finishedNext;
    end
  end

  assign DOUT       = r_dout;
  assign PE         = r_pe;
  assign FE         = r_fe;
  assign BI         = r_bi;
  assign RXFINISHED = r_finished;
  assign BUSY       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_bit_sequencer.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_bit_sequencer
//
// Directed bench for uart_rx_bit_sequencer. A table of frame records
// (format, bits on the line, expected character and flags) is replayed in a
// loop; glitch, break, back-to-back, CLEAR and mid-frame reset sequences are
// written out by hand. One baud tick is issued every 4 CLKs.
// ---------------------------------------------------------------------------
module tb_uart_rx_bit_sequencer;

  logic       CLK;
  logic       RST;
  logic       RXCLK;
  logic       CLEAR;
  logic       RXD;
  logic [1:0] WLS;
  logic       PEN;
  logic       EPS;
  logic       SP;
  logic [7:0] DOUT;
  logic       PE;
  logic       FE;
  logic       BI;
  logic       RXFINISHED;
  logic       BUSY;

  uart_rx_bit_sequencer dut (
    .CLK        (CLK),
    .RST        (RST),
    .RXCLK      (RXCLK),
    .CLEAR      (CLEAR),
    .RXD        (RXD),
    .WLS        (WLS),
    .PEN        (PEN),
    .EPS        (EPS),
    .SP         (SP),
    .DOUT       (DOUT),
    .PE         (PE),
    .FE         (FE),
    .BI         (BI),
    .RXFINISHED (RXFINISHED),
    .BUSY       (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] data;
    logic [1:0] wls;
    logic       pen;
    logic       eps;
    logic       sp;
    logic       parBit;
    logic       stopBit;
    logic [7:0] expDout;
    logic       expPe;
    logic       expFe;
    logic       expBi;
  } vec_t;

  vec_t vecs[11];

  int checkCount = 0;
  int missCount  = 0;
  int tickCount  = 0;
  int curTick    = 0;
  int frameStart = 0;
  int strobeCount = 0;
  int strobeTick  = 0;
  logic [7:0] capDout[64];
  logic       capPe[64];
  logic       capFe[64];
  logic       capBi[64];

  // Compare one observed value against the bench's expectation.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Advance one CLK, sample outputs 1ns after the edge, and log any strobe.
  task automatic clkStep();
    @(posedge CLK);
    #1;
    if (RXFINISHED === 1'b1) begin
      capDout[strobeCount % 64] = DOUT;
      capPe[strobeCount % 64]   = PE;
      capFe[strobeCount % 64]   = FE;
      capBi[strobeCount % 64]   = BI;
      strobeTick = curTick;
      strobeCount++;
    end
  endtask

  // One baud tick: RXCLK high for one CLK, then three idle CLKs.
  task automatic doTick(input logic rxd);
    curTick = tickCount;
    tickCount++;
    RXD   = rxd;
    RXCLK = 1'b1;
    clkStep();
    RXCLK = 1'b0;
    repeat (3) clkStep();
  endtask

  // Put one whole frame on the line: start, data LSB first, parity, stop.
  task automatic sendFrame(input logic [7:0] data, input int nBits,
                           input logic pen, input logic parBit,
                           input logic stopBit);
    frameStart = tickCount;
    repeat (16) doTick(1'b0);
    for (int i = 0; i < nBits; i++) begin
      repeat (16) doTick(data[i]);
    end
    if (pen) repeat (16) doTick(parBit);
    repeat (16) doTick(stopBit);
  endtask

  // Configure the line format for a table entry and transmit its frame.
  task automatic applyStimulus(input vec_t v);
    WLS = v.wls;
    PEN = v.pen;
    EPS = v.eps;
    SP  = v.sp;
    sendFrame(v.data, 5 + int'(v.wls), v.pen, v.parBit, v.stopBit);
  endtask

  initial begin
    int base;
    int expLat;

    //                data   wls   pen   eps   sp    par   stop  dout   pe    fe    bi
    vecs[0]  = '{8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{8'h13, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h13, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{8'h13, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h13, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{8'h55, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{8'h55, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{8'h2A, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h2A, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{8'h2A, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h2A, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{8'h81, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{8'h00, 2'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{8'h00, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{8'hFF, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h1F, 1'b0, 1'b0, 1'b0};

    RST   = 1'b1;
    RXCLK = 1'b0;
    CLEAR = 1'b0;
    RXD   = 1'b1;
    WLS   = 2'd3;
    PEN   = 1'b0;
    EPS   = 1'b0;
    SP    = 1'b0;

    // Reset values.
    repeat (2) clkStep();
    checkOutput("reset DOUT", 32'(DOUT), 32'h00);
    checkOutput("reset PE", 32'(PE), 32'h0);
    checkOutput("reset FE", 32'(FE), 32'h0);
    checkOutput("reset BI", 32'(BI), 32'h0);
    checkOutput("reset RXFINISHED", 32'(RXFINISHED), 32'h0);
    checkOutput("reset BUSY", 32'(BUSY), 32'h0);
    RST = 1'b0;
    repeat (3) doTick(1'b1);
    checkOutput("idle BUSY", 32'(BUSY), 32'h0);

    // Table-driven frames.
    for (int i = 0; i < 11; i++) begin
      base = strobeCount;
      applyStimulus(vecs[i]);
      repeat (3) doTick(1'b1);
      expLat = 8 + 16 * (5 + int'(vecs[i].wls) + 1 + int'(vecs[i].pen));
      checkOutput($sformatf("v%0d strobes", i), 32'(strobeCount - base), 32'd1);
      checkOutput($sformatf("v%0d latency", i), 32'(strobeTick - frameStart), 32'(expLat));
      checkOutput($sformatf("v%0d DOUT", i), 32'(capDout[base % 64]), 32'(vecs[i].expDout));
      checkOutput($sformatf("v%0d PE", i), 32'(capPe[base % 64]), 32'(vecs[i].expPe));
      checkOutput($sformatf("v%0d FE", i), 32'(capFe[base % 64]), 32'(vecs[i].expFe));
      checkOutput($sformatf("v%0d BI", i), 32'(capBi[base % 64]), 32'(vecs[i].expBi));
      checkOutput($sformatf("v%0d BUSY after", i), 32'(BUSY), 32'h0);
    end

    // Glitch: line low for 4 ticks only, false start rejected at t8.
    WLS = 2'd3; PEN = 1'b0; EPS = 1'b0; SP = 1'b0;
    base = strobeCount;
    repeat (4) doTick(1'b0);
    repeat (4) doTick(1'b1);
    checkOutput("glitch BUSY at t7", 32'(BUSY), 32'h1);
    doTick(1'b1);
    checkOutput("glitch BUSY after t8", 32'(BUSY), 32'h0);
    checkOutput("glitch no strobe", 32'(strobeCount - base), 32'd0);
    repeat (2) doTick(1'b1);
    sendFrame(8'h3C, 8, 1'b0, 1'b0, 1'b1);
    repeat (2) doTick(1'b1);
    checkOutput("post-glitch strobes", 32'(strobeCount - base), 32'd1);
    checkOutput("post-glitch DOUT", 32'(capDout[base % 64]), 32'h3C);

    // Break: line low for two whole 8N1 frames.
    base = strobeCount;
    repeat (320) doTick(1'b0);
    checkOutput("break strobes", 32'(strobeCount - base), 32'd1);
    checkOutput("break DOUT", 32'(capDout[base % 64]), 32'h00);
    checkOutput("break PE", 32'(capPe[base % 64]), 32'h0);
    checkOutput("break FE", 32'(capFe[base % 64]), 32'h1);
    checkOutput("break BI", 32'(capBi[base % 64]), 32'h1);
    checkOutput("break BUSY held", 32'(BUSY), 32'h1);
    doTick(1'b1);
    checkOutput("break release BUSY", 32'(BUSY), 32'h0);
    repeat (2) doTick(1'b1);

    // Back-to-back frames, 7-bit stick parity (expected parity bit 1).
    WLS = 2'd2; PEN = 1'b1; EPS = 1'b0; SP = 1'b1;
    base = strobeCount;
    sendFrame(8'h41, 7, 1'b1, 1'b1, 1'b1);
    sendFrame(8'h42, 7, 1'b1, 1'b1, 1'b1);
    repeat (2) doTick(1'b1);
    checkOutput("b2b strobes", 32'(strobeCount - base), 32'd2);
    checkOutput("b2b DOUT0", 32'(capDout[base % 64]), 32'h41);
    checkOutput("b2b DOUT1", 32'(capDout[(base + 1) % 64]), 32'h42);
    checkOutput("b2b PE0", 32'(capPe[base % 64]), 32'h0);
    checkOutput("b2b PE1", 32'(capPe[(base + 1) % 64]), 32'h0);

    // CLEAR during data bit 3 of an 0xFF frame; DOUT keeps 0x5A.
    WLS = 2'd3; PEN = 1'b0; EPS = 1'b0; SP = 1'b0;
    sendFrame(8'h5A, 8, 1'b0, 1'b0, 1'b1);
    repeat (2) doTick(1'b1);
    base = strobeCount;
    repeat (16) doTick(1'b0);
    repeat (56) doTick(1'b1);
    checkOutput("pre-clear BUSY", 32'(BUSY), 32'h1);
    CLEAR = 1'b1;
    clkStep();
    CLEAR = 1'b0;
    checkOutput("clear BUSY", 32'(BUSY), 32'h0);
    checkOutput("clear DOUT held", 32'(DOUT), 32'h5A);
    repeat (100) doTick(1'b1);
    checkOutput("clear no strobe", 32'(strobeCount - base), 32'd0);
    checkOutput("clear idle BUSY", 32'(BUSY), 32'h0);

    // Reset mid-frame: outputs return to reset values without a clock edge.
    repeat (16) doTick(1'b0);
    repeat (20) doTick(1'b1);
    checkOutput("pre-reset BUSY", 32'(BUSY), 32'h1);
    RST = 1'b1;
    #1;
    checkOutput("async reset DOUT", 32'(DOUT), 32'h00);
    checkOutput("async reset PE", 32'(PE), 32'h0);
    checkOutput("async reset FE", 32'(FE), 32'h0);
    checkOutput("async reset BI", 32'(BI), 32'h0);
    checkOutput("async reset BUSY", 32'(BUSY), 32'h0);
    checkOutput("async reset RXFINISHED", 32'(RXFINISHED), 32'h0);
    repeat (2) clkStep();
    RST = 1'b0;
    repeat (120) doTick(1'b1);
    checkOutput("reset no strobe", 32'(strobeCount - base), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", checkCount, missCount);
    $finish;
  end

endmodule
